// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the asynchronous 4096x4 Ram: A = CPU, B = loader/debug.
// Optional RAM_ARB_ROUNDROBIN_EN: round-robin tie-break (default: fixed priority to port A).
module ram_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqA,
    input  logic                  reqB,
    input  logic                  writeA,
    input  logic                  writeB,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] wdataA,
    input  logic [DATA_WIDTH-1:0] wdataB,
    output logic                  ackA,
    output logic                  ackB,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  notChipEnable,
    output logic                  notWriteEnable,
    inout  wire  [DATA_WIDTH-1:0] io
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  grant_b_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  nce_q;
    logic                  nwe_q;
    logic                  oe_q;
    logic                  ack_a_q;
    logic                  ack_b_q;
    logic                  grant_b_d;

`ifdef RAM_ARB_ROUNDROBIN_EN
    // Set when B was not granted last, so B wins the next tie.
    logic prio_b_q;
    assign grant_b_d = reqB && (!reqA || prio_b_q);
`else
    assign grant_b_d = reqB && !reqA;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_b_q <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            address_q <= '0;
            rdata_q   <= '0;
            nce_q     <= 1'b1;
            nwe_q     <= 1'b1;
            oe_q      <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
`ifdef RAM_ARB_ROUNDROBIN_EN
            prio_b_q  <= 1'b0;
`endif
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqA || reqB) begin
                        grant_b_q <= grant_b_d;
                        write_q   <= grant_b_d ? writeB : writeA;
                        address_q <= grant_b_d ? addrB  : addrA;
                        wdata_q   <= grant_b_d ? wdataB : wdataA;
                        state_q   <= SETUP;
`ifdef RAM_ARB_ROUNDROBIN_EN
                        prio_b_q  <= !grant_b_d;
`endif
                    end
                end
                SETUP: begin
                    // Chip and write enables fall together; address has had a full cycle to settle.
                    nce_q   <= 1'b0;
                    nwe_q   <= !write_q;
                    oe_q    <= write_q;
                    cnt_q   <= CW'(WAIT_CYCLES - 1);
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        nce_q   <= 1'b1;
                        nwe_q   <= 1'b1;
                        oe_q    <= 1'b0;
                        ack_a_q <= !grant_b_q;
                        ack_b_q <= grant_b_q;
                        if (!write_q) rdata_q <= io;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io             = oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ackA           = ack_a_q;
    assign ackB           = ack_b_q;
    assign rdata          = rdata_q;
    assign address        = address_q;
    assign notChipEnable  = nce_q;
    assign notWriteEnable = nwe_q;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the Nibbler 4096×4 asynchronous data `Ram`. It shares the `Ram` between the CPU (port A) and the program loader/debug port (port B). It converts each requester's synchronous req/ack handshake into a correctly ordered chip-enable/write-enable/address/io sequence on the `Ram`'s active-low pins. All `Ram`-side outputs are registered, so the `Ram` sees glitch-free strobes.

## Interface
- `ADDR_WIDTH`, 12, `Ram` address width.
- `DATA_WIDTH`, 4, `Ram` data width (nibble).
- `WAIT_CYCLES`, 1, cycles `notChipEnable` is held low per access (≥1).
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `reqA` / `reqB`  in  1  access request; held high until the matching ack.
- `writeA` / `writeB`  in  1  1 = write, 0 = read; held stable with req.
- `addrA` / `addrB`  in  ADDR_WIDTH  access address; held stable with req.
- `wdataA` / `wdataB`  in  DATA_WIDTH  write data; held stable with req.
- `ackA` / `ackB`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_WIDTH  read data; valid in the ack cycle and held until the next read completes.
- `address`  out  ADDR_WIDTH  to `Ram` address.
- `notChipEnable`  out  1  to `Ram`, active low.
- `notWriteEnable`  out  1  to `Ram`, active low.
- `io`  inout  DATA_WIDTH  `Ram` data bus; driven only during write ACCESS, otherwise `4'bzzzz`.

## Operation
- FSM states and transitions: IDLE → SETUP → ACCESS (WAIT_CYCLES cycles) → DONE → IDLE.
- IDLE:
  - Samples `reqA`/`reqB`.
  - On a request, latches the winner's write, address and data and records the grant.
  - With no request, stays in IDLE with `notChipEnable`=`notWriteEnable`=1.
- SETUP:
  - `address` is driven to the latched address.
  - `notChipEnable`=1 and `notWriteEnable`=1.
  - `io` is Z.
- ACCESS:
  - `notChipEnable`=0.
  - Write: `notWriteEnable`=0 and `io` is driven with the latched data.
  - Read: `notWriteEnable`=1 and `io` is Z; `io` is captured into `rdata` on the final ACCESS edge.
  - An internal counter counts WAIT_CYCLES, then moves the FSM to DONE.
- DONE:
  - `notChipEnable`=1, `notWriteEnable`=1 and `io` is Z.
  - `address` is held one more cycle for hold time.
  - The granted port's ack is pulsed.
- Arbitration is sampled only in IDLE; a grant is never preempted.
- Simultaneous `reqA`/`reqB`: see Configuration. A lone request is always granted.
- The requester drops req on the edge at which it observes ack. A req still high in the IDLE cycle after DONE is treated as a new request.
- Writes and reads to any address (0x000–0xFFF) are legal; `address` does not wrap or increment.

## Timing
- Reset values:
  - FSM in IDLE; `notChipEnable`=1, `notWriteEnable`=1.
  - `address`=0, `io`=Z, `ackA`=`ackB`=0, `rdata`=0.
  - Round-robin pointer set so port A wins the first tie.
- Latency: with req high at IDLE edge N, SETUP is cycle N+1 and ACCESS covers N+2 … N+1+WAIT_CYCLES. Ack is high in cycle N+2+WAIT_CYCLES (3 cycles at default).
- Throughput: one access per WAIT_CYCLES+3 cycles, IDLE included.
- `notWriteEnable` falls no earlier than `notChipEnable` and rises at the same edge. `address` is stable from SETUP through DONE.
- Reset mid-operation: on the reset edge, strobes return high, `io` goes Z and the FSM returns to IDLE. No ack is issued and a partial write is not retried.

## Configuration
- `RAM_ARB_ROUNDROBIN_EN` defined:
  - A tie goes to the port not granted most recently.
  - The pointer updates on every grant.
- Undefined:
  - Fixed priority: port A (CPU) always wins ties.
  - Port B waits until port A is idle in an IDLE cycle.

## Test plan
- Reset during a write ACCESS → next cycle `notChipEnable`=1, `notWriteEnable`=1, `io`=Z, no ack. A later read of that address returns the old or new data without an X on the strobes.
- `reqA` write addr 0x000 data 0x3, then `reqA` read 0x000 → `ackA` 3 cycles after each req; `notWriteEnable` is low exactly 1 cycle; `rdata`=0x3 with `ackA`.
- `reqB` write 0xF7B data 0x9, then `reqB` read 0xF7B → `rdata`=0x9 and `ackA` stays 0 throughout.
- `reqA` and `reqB` asserted in the same cycle with WAIT_CYCLES=1:
  - Without the macro: A is served first, B is acked 4 cycles after A.
  - With the macro and repeated ties: grants alternate A, B, A, B.
- `reqA` held high continuously for back-to-back reads of 0x001 and 0x002 → one access every 4 cycles, with `notChipEnable` high for at least 2 cycles between accesses.
